lms_coef_fir: RTL and testbench

Fixed-coefficient FIR that applies weight vectors exported by the adaptive LMS filter to a separate sample stream. It is the consumer side of the weight interface: the LMS produces weights, and this block latches a snapshot and filters with it. It uses a single time-multiplexed multiplier. The arithmetic is the same Q1.7 arithmetic the LMS uses, so its output is bit-exact against the LMS output for identical taps and weights.

---
 rtl/lms_coef_fir.sv | 94 +++++++++
 tb/tb_lms_coef_fir.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lms_coef_fir.sv
// lms_coef_fir: time-multiplexed Q1.7 FIR applying a latched snapshot of LMS weight vectors.
// Weights arriving while a sample is in flight are shadowed and committed on the OUT->IDLE edge.
module lms_coef_fir #(
    parameter int N = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] w_in [N-1:0],
    input  logic                    w_load,
    output logic                    coef_updated,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    ovf
);
    localparam int KW = $clog2(N);
    localparam int AW = 2 * WIDTH + KW;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] x_reg [N-1:0];
    logic signed [WIDTH-1:0] coef [N-1:0];
    logic signed [WIDTH-1:0] sh [N-1:0];
    logic                    pending;
    logic [KW-1:0]           k;
    logic signed [AW-1:0]    acc, acc_nx, scaled;
    logic signed [2*WIDTH-1:0] prod;
    logic                    accept, last, done, ovf_nx;

    always_comb begin
        x_ready  = state == IDLE;
        accept   = x_ready && x_valid;
        last     = state == MAC && k == KW'(N - 1);
        done     = state == OUT && y_ready;
        prod     = x_reg[k] * coef[k];
        acc_nx   = acc + AW'(prod);
        scaled   = acc_nx >>> 7;
        ovf_nx   = scaled != {{(AW-WIDTH){scaled[WIDTH-1]}}, scaled[WIDTH-1:0]};
        state_nx = accept ? MAC : last ? OUT : done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_reg        <= '{default: '0};
            coef         <= '{default: '0};
            sh           <= '{default: '0};
            pending      <= 1'b0;
            k            <= '0;
            acc          <= '0;
            y_out        <= '0;
            y_valid      <= 1'b0;
            ovf          <= 1'b0;
            coef_updated <= 1'b0;
        end else begin
            state        <= state_nx;
            coef_updated <= 1'b0;
            if (accept) begin
                x_reg[0] <= x_in;
                for (int i = 1; i < N; i++) x_reg[i] <= x_reg[i-1];
                acc <= '0;
                k   <= '0;
            end
            if (state == MAC) begin
                acc <= acc_nx;
                k   <= k + KW'(1);
            end
            if (last) begin
                y_out   <= scaled[WIDTH-1:0];
                ovf     <= ovf_nx;
                y_valid <= 1'b1;
            end
            if (done) y_valid <= 1'b0;
            // a fresh load on the commit edge supersedes the shadow copy
            if (w_load && (state == IDLE || done)) begin
                coef         <= w_in;
                pending      <= 1'b0;
                coef_updated <= 1'b1;
            end else if (done && pending) begin
                coef         <= sh;
                pending      <= 1'b0;
                coef_updated <= 1'b1;
            end else if (w_load) begin
                sh      <= w_in;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lms_coef_fir.sv
// tb_lms_coef_fir: randomized and directed stimulus against a cycle-level reference model.
// A negedge monitor predicts handshakes, coefficient commits and filtered values, and scores the DUT.
module tb_lms_coef_fir;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [7:0] w_in [N-1:0];
    logic w_load = 1'b0;
    logic coef_updated;
    logic signed [7:0] x_in = '0;
    logic x_valid = 1'b0;
    logic x_ready;
    logic signed [7:0] y_out;
    logic y_valid;
    logic y_ready = 1'b1;
    logic ovf;

    int checks = 0;
    int errors = 0;

    int hist [N];
    int coef_m [N];
    int sh_m [N];
    bit pend = 0, busy = 0, mvalid = 0, m_upd = 0, chk_zero = 0;
    int cnt = 0;
    int exp_y[$], exp_o[$], obs_y[$], obs_o[$];

    lms_coef_fir #(.N(N), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .w_in(w_in), .w_load(w_load), .coef_updated(coef_updated),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready), .y_out(y_out),
        .y_valid(y_valid), .y_ready(y_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic take_w(output int dst [N]);
        for (int i = 0; i < N; i++) dst[i] = int'(w_in[i]);
    endtask

    // Reference: full-precision dot product, floor by 128, wrap to 8 bits.
    task automatic predict();
        int s, sc, y8;
        s = 0;
        for (int i = 0; i < N; i++) s += hist[i] * coef_m[i];
        sc = s >>> 7;
        y8 = sc & 255;
        if (y8 > 127) y8 -= 256;
        exp_y.push_back(y8);
        exp_o.push_back((sc > 127 || sc < -128) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        chk("x_ready", int'(x_ready), int'(!busy));
        chk("y_valid", int'(y_valid), int'(mvalid));
        chk("coef_updated", int'(coef_updated), int'(m_upd));
        if (chk_zero) begin
            chk("rst_y_out", int'(y_out), 0);
            chk("rst_ovf", int'(ovf), 0);
            chk_zero = 0;
        end
        if (mvalid && y_valid) begin
            if (exp_y.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                chk("y_out", int'(y_out), exp_y[0]);
                chk("ovf", int'(ovf), exp_o[0]);
                if (y_ready) begin
                    obs_y.push_back(int'(y_out));
                    obs_o.push_back(int'(ovf));
                    void'(exp_y.pop_front());
                    void'(exp_o.pop_front());
                end
            end
        end
        m_upd = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin hist[i] = 0; coef_m[i] = 0; sh_m[i] = 0; end
            pend = 0; busy = 0; mvalid = 0; cnt = 0; chk_zero = 1;
            exp_y.delete(); exp_o.delete();
        end else if (!busy) begin
            if (w_load) begin take_w(coef_m); m_upd = 1; end
            if (x_valid) begin
                for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(x_in);
                predict();
                busy = 1; cnt = 0;
            end
        end else if (mvalid && y_ready) begin
            busy = 0; mvalid = 0;
            if (w_load) begin take_w(coef_m); pend = 0; m_upd = 1; end
            else if (pend) begin coef_m = sh_m; pend = 0; m_upd = 1; end
        end else begin
            if (w_load) begin take_w(sh_m); pend = 1; end
            if (!mvalid) begin cnt++; if (cnt == N) mvalid = 1; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        obs_y.delete(); obs_o.delete();
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3);
        w_in[0] = 8'(w0); w_in[1] = 8'(w1); w_in[2] = 8'(w2); w_in[3] = 8'(w3);
        w_load = 1'b1; tick(); w_load = 1'b0;
    endtask

    task automatic send(input int x);
        bit ok = 0;
        x_in = 8'(x); x_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = x_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        tick(); x_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lows);
        bit ok = 0;
        lows = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (x_ready) ok = 1; else lows++;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lows;
        bit seen;
        for (int i = 0; i < N; i++) w_in[i] = '0;
        do_reset();
        chk("reset_x_ready", int'(x_ready), 1);
        chk("reset_y_valid", int'(y_valid), 0);

        load(64, 0, 0, 0); send(100); wait_idle(lows);
        chk("single_tap_y", obs_y[0], 50);
        chk("single_tap_ovf", obs_o[0], 0);

        do_reset();
        load(10, 20, 30, 40);
        foreach (obs_y[i]) ;
        send(127); wait_idle(lows); chk("impulse_xready_low", lows, N + 1);
        for (int i = 0; i < 3; i++) begin send(0); wait_idle(lows); chk("impulse_xready_low", lows, N + 1); end
        chk("impulse_count", obs_y.size(), 4);
        if (obs_y.size() == 4) begin
            chk("impulse_0", obs_y[0], 9); chk("impulse_1", obs_y[1], 19);
            chk("impulse_2", obs_y[2], 29); chk("impulse_3", obs_y[3], 39);
        end

        do_reset();
        load(64, 0, 0, 0); send(-128); wait_idle(lows);
        chk("negative_y", obs_y[0], -64);
        load(127, 127, 127, 127);
        for (int i = 0; i < 4; i++) begin send(127); wait_idle(lows); end
        chk("overflow_y", obs_y[4], -8);
        chk("overflow_ovf", obs_o[4], 1);

        do_reset();
        load(64, 0, 0, 0);
        y_ready = 1'b0;
        send(50);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = y_valid; end
        chk("bp_valid_seen", int'(seen), 1);
        tick();
        x_in = 8'sd33; x_valid = 1'b1;
        repeat (10) tick();
        x_valid = 1'b0; y_ready = 1'b1;
        wait_idle(lows);
        chk("bp_count", obs_y.size(), 1);
        chk("bp_y", obs_y[0], 25);

        do_reset();
        load(10, 0, 0, 0); send(127);
        tick(); tick();
        load(20, 0, 0, 0);
        wait_idle(lows);
        send(127); wait_idle(lows);
        chk("midmac_count", obs_y.size(), 2);
        chk("midmac_first", obs_y[0], 9);
        chk("midmac_second", obs_y[1], 19);

        do_reset();
        load(10, 20, 30, 40); send(127);
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (N + 3) tick();
        chk("rst_mac_no_output", obs_y.size(), 0);
        send(55); wait_idle(lows);
        chk("rst_mac_zero_coef", obs_y[0], 0);

        do_reset();
        for (int c = 0; c < 1500; c++) begin
            x_valid = ($urandom_range(0, 1) == 1);
            x_in = 8'($urandom);
            w_load = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) w_in[i] = 8'($urandom);
            y_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        x_valid = 1'b0; w_load = 1'b0; y_ready = 1'b1;
        wait_idle(lows);
        chk("random_drained", exp_y.size(), 0);
        chk("random_outputs_seen", int'(obs_y.size() > 20), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
